// File: rtl/plasma_clk_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, lock-loss
// counter width and small counter helpers.
package plasma_clk_pkg;

    localparam int LOCK_LOSS_W = 8;

    typedef enum logic [2:0] {
        SEQ_PLL_RST   = 3'd0,
        SEQ_WAIT_LOCK = 3'd1,
        SEQ_RELEASE   = 3'd2,
        SEQ_RUN       = 3'd3,
        SEQ_FAIL      = 3'd4
    } seq_state_e;

    // Width needed to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [LOCK_LOSS_W-1:0] sat_inc(input logic [LOCK_LOSS_W-1:0] v);
        return (&v) ? v : v + LOCK_LOSS_W'(1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; all flops clear
// to 0 on reset so an unqualified input reads as "not locked".
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor on the free-running reference clock: pulses the PLL reset,
// qualifies lock, releases channel resets in a stagger and recovers on loss.
module pll_reset_sequencer
    import plasma_clk_pkg::*;
#(
    parameter int NUM_CH              = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 0
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic                   pll_rst,
    output logic [NUM_CH-1:0]      ch_rst_n,
    output logic                   lock_ok,
    output logic                   fail,
    output logic [2:0]             state,
    output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

    localparam int K_LAST = (NUM_CH - 1) * STAGGER_CYCLES + 1;
    localparam int RST_W  = cnt_w(PLL_RST_CYCLES);
    localparam int STB_W  = cnt_w(LOCK_STABLE_CYCLES);
    localparam int TMO_W  = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int K_W    = cnt_w(K_LAST);
    localparam int RTY_W  = cnt_w(MAX_RETRIES);

    // Counters hold "cycles already spent", so the limit test is against limit-1.
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [K_W-1:0]   K_RUN    = K_W'(K_LAST);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic lk;

    seq_state_e             state_q, state_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [RTY_W-1:0]       rty_q, rty_d;
    logic [RTY_W-1:0]       rty_inc;
    logic [NUM_CH-1:0]      ch_q, ch_d;
    logic [LOCK_LOSS_W-1:0] llc_q, llc_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   lock_ok_q, lock_ok_d;
    logic                   fail_q, fail_d;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d_i  (pll_locked),
        .q_o  (lk)
    );

    assign rty_inc = rty_q + RTY_W'(1);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        stb_cnt_d = '0;
        tmo_cnt_d = '0;
        k_d       = '0;
        rty_d     = rty_q;
        ch_d      = '0;
        llc_d     = llc_q;

        if (sw_reset_req) begin
            state_d = SEQ_PLL_RST;
            rty_d   = '0;
        end else begin
            case (state_q)
                SEQ_PLL_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = SEQ_WAIT_LOCK;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end

                SEQ_WAIT_LOCK: begin
                    // Qualification is tested first so it wins a same-cycle timeout.
                    if (lk && (stb_cnt_q == STB_LAST)) begin
                        state_d = SEQ_RELEASE;
                        rty_d   = '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        if (MAX_RETRIES != 0) begin
                            rty_d = rty_inc;
                        end
                        if ((MAX_RETRIES != 0) && (rty_inc == RTY_MAX)) begin
                            state_d = SEQ_FAIL;
                        end else begin
                            state_d = SEQ_PLL_RST;
                        end
                    end else begin
                        stb_cnt_d = lk ? stb_cnt_q + STB_W'(1) : '0;
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end

                SEQ_RELEASE: begin
                    if (!lk) begin
                        state_d = SEQ_PLL_RST;
                        llc_d   = sat_inc(llc_q);
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            ch_d[i] = ch_q[i] | (k_q == K_W'(i * STAGGER_CYCLES));
                        end
                        if (k_q == K_RUN) begin
                            state_d = SEQ_RUN;
                        end else begin
                            k_d = k_q + K_W'(1);
                        end
                    end
                end

                SEQ_RUN: begin
                    if (!lk) begin
                        state_d = SEQ_PLL_RST;
                        llc_d   = sat_inc(llc_q);
                    end else begin
                        ch_d = '1;
                    end
                end

                SEQ_FAIL: begin
                    state_d = SEQ_FAIL;
                end

                default: begin
                    state_d = SEQ_PLL_RST;
                end
            endcase
        end

        // Status outputs are registered copies of the next state.
        pll_rst_d = (state_d == SEQ_PLL_RST) || (state_d == SEQ_FAIL);
        lock_ok_d = (state_d == SEQ_RUN);
        fail_d    = (state_d == SEQ_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEQ_PLL_RST;
            rst_cnt_q <= '0;
            stb_cnt_q <= '0;
            tmo_cnt_q <= '0;
            k_q       <= '0;
            rty_q     <= '0;
            ch_q      <= '0;
            llc_q     <= '0;
            pll_rst_q <= 1'b1;
            lock_ok_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            k_q       <= k_d;
            rty_q     <= rty_d;
            ch_q      <= ch_d;
            llc_q     <= llc_d;
            pll_rst_q <= pll_rst_d;
            lock_ok_q <= lock_ok_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign ch_rst_n      = ch_q;
    assign lock_ok       = lock_ok_q;
    assign fail          = fail_q;
    assign state         = state_q;
    assign lock_loss_cnt = llc_q;

endmodule
